// File: rtl/mpbuffer_pkg.sv
// -----------------------------------------------------------------------------
// mpbuffer_pkg
// Shared types and helpers for the message-passing buffer channel mux:
//   - config_t         : minimal NoC configuration (flit width)
//   - eg_state_t       : egress arbiter states
//   - in_state_t       : ingress demux states
//   - rr_result_t      : round-robin search result (found bit + index)
//   - clog2_width()    : index width for a channel count, never below 1
//   - rr_select()      : first valid requester at or after a pointer, with wrap
// -----------------------------------------------------------------------------
package mpbuffer_pkg;

  typedef struct packed {
    int unsigned NOC_FLIT_WIDTH;
  } config_t;

  localparam config_t DEFAULT_CONFIG = '{NOC_FLIT_WIDTH: 32'd32};

  localparam int DROP_COUNT_WIDTH = 16;

  typedef enum logic [0:0] {
    EG_IDLE = 1'b0,
    EG_LOCK = 1'b1
  } eg_state_t;

  typedef enum logic [1:0] {
    IN_HEAD  = 2'd0,
    IN_ROUTE = 2'd1,
    IN_DROP  = 2'd2
  } in_state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_result_t;

  // A single channel still needs a one-bit index field.
  function automatic int clog2_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Searches valid[ptr], valid[ptr+1], ... wrapping at n; n is 1..8.
  function automatic rr_result_t rr_select(input logic [7:0] valid,
                                           input logic [2:0] ptr,
                                           input int         n);
    rr_result_t res;
    int         j;
    res.found = 1'b0;
    res.idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (k < n) begin
        j = (int'(ptr) + k) % n;
        if (!res.found && valid[j]) begin
          res.found = 1'b1;
          res.idx   = 3'(j);
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/noc_rr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_packet_arbiter
// Packet-atomic round-robin arbiter of N flit streams onto one link. A packet
// that starts transferring keeps the link until its last flit transfers; the
// round-robin pointer then moves past the winner. No storage: the selected
// source is forwarded combinationally.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   src_flit  [N*W]       source flits, source i at [i*W +: W]
//   src_last  [N]         source last-flit flags
//   src_valid [N]         source valid
//   src_ready [N]         source ready, one-hot or zero
//   dst_flit  [W]         forwarded flit
//   dst_last              forwarded last flag
//   dst_valid             forwarded valid
//   dst_ready             ready from the link
// -----------------------------------------------------------------------------
module noc_rr_packet_arbiter
  import mpbuffer_pkg::*;
#(
  parameter int N = 2,
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] src_flit,
  input  logic [N-1:0]   src_last,
  input  logic [N-1:0]   src_valid,
  output logic [N-1:0]   src_ready,
  output logic [W-1:0]   dst_flit,
  output logic           dst_last,
  output logic           dst_valid,
  input  logic           dst_ready
);

  localparam int CW = clog2_width(N);

  eg_state_t     state;
  logic [CW-1:0] grant;
  logic [CW-1:0] rr_ptr;

  rr_result_t    cand;
  logic [CW-1:0] cand_idx;
  logic [CW-1:0] cur;
  logic          active;
  logic          cur_valid;
  logic          xfer;
  logic [CW-1:0] next_ptr;

  // Source selection: locked grant, or this cycle's round-robin candidate.
  always_comb begin
    cand     = rr_select(8'(src_valid), 3'(rr_ptr), N);
    cand_idx = '0;
    for (int i = 0; i < N; i++) begin
      cand_idx = (cand.idx == 3'(i)) ? CW'(i) : cand_idx;
    end

    if (state == EG_LOCK) begin
      cur    = grant;
      active = 1'b1;
    end else begin
      cur    = cand_idx;
      active = cand.found;
    end

    dst_flit  = '0;
    dst_last  = 1'b0;
    cur_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      dst_flit     = (cur == CW'(i)) ? src_flit[i*W +: W] : dst_flit;
      dst_last     = (cur == CW'(i)) ? src_last[i] : dst_last;
      cur_valid    = (cur == CW'(i)) ? src_valid[i] : cur_valid;
      // Ready is also qualified by valid so an idle source never sees ready.
      src_ready[i] = active && (cur == CW'(i)) && src_valid[i] && dst_ready;
    end

    dst_valid = active && cur_valid;
    xfer      = dst_valid && dst_ready;
    // Explicit wrap so non-power-of-two N never reaches index N.
    next_ptr  = (cur == CW'(N - 1)) ? '0 : cur + CW'(1);
  end

  // Egress FSM: lock on a multi-flit packet, release and advance pointer on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EG_IDLE;
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        EG_IDLE: begin
          if (xfer) begin
            if (dst_last) begin
              rr_ptr <= next_ptr;
            end else begin
              state <= EG_LOCK;
              grant <= cur;
            end
          end
        end
        EG_LOCK: begin
          if (xfer && dst_last) begin
            state  <= EG_IDLE;
            rr_ptr <= next_ptr;
          end
        end
        default: begin
          state <= EG_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/mpbuffer_channel_mux.sv
// -----------------------------------------------------------------------------
// mpbuffer_channel_mux
// Shares one NoC endpoint link between CHANNELS message-passing buffer
// endpoints. Egress packets are arbitrated round-robin, packet-atomically.
// Ingress packets are steered by a channel index in the header flit; packets
// whose index has no endpoint are swallowed and counted. Zero added latency.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ep_out_*          egress streams from endpoints (flit i at [i*FW +: FW])
//   noc_out_*         egress stream to the NoC
//   noc_in_*          ingress stream from the NoC
//   ep_in_flit/last   ingress flit/last, broadcast to all endpoints
//   ep_in_valid/ready ingress handshake per endpoint, valid one-hot or zero
//   drop_count        saturating count of dropped ingress packets
// -----------------------------------------------------------------------------
module mpbuffer_channel_mux
  import mpbuffer_pkg::*;
#(
  parameter config_t CONFIG   = DEFAULT_CONFIG,
  parameter int      CHANNELS = 2,
  parameter int      CH_LSB   = 16,
  localparam int     FW       = int'(CONFIG.NOC_FLIT_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [CHANNELS*FW-1:0]      ep_out_flit,
  input  logic [CHANNELS-1:0]         ep_out_last,
  input  logic [CHANNELS-1:0]         ep_out_valid,
  output logic [CHANNELS-1:0]         ep_out_ready,
  output logic [FW-1:0]               noc_out_flit,
  output logic                        noc_out_last,
  output logic                        noc_out_valid,
  input  logic                        noc_out_ready,
  input  logic [FW-1:0]               noc_in_flit,
  input  logic                        noc_in_last,
  input  logic                        noc_in_valid,
  output logic                        noc_in_ready,
  output logic [FW-1:0]               ep_in_flit,
  output logic                        ep_in_last,
  output logic [CHANNELS-1:0]         ep_in_valid,
  input  logic [CHANNELS-1:0]         ep_in_ready,
  output logic [DROP_COUNT_WIDTH-1:0] drop_count
);

  localparam int CW = clog2_width(CHANNELS);
  localparam logic [DROP_COUNT_WIDTH-1:0] DROP_MAX = {DROP_COUNT_WIDTH{1'b1}};

  noc_rr_packet_arbiter #(
    .N (CHANNELS),
    .W (FW)
  ) u_egress (
    .clk       (clk),
    .rst       (rst),
    .src_flit  (ep_out_flit),
    .src_last  (ep_out_last),
    .src_valid (ep_out_valid),
    .src_ready (ep_out_ready),
    .dst_flit  (noc_out_flit),
    .dst_last  (noc_out_last),
    .dst_valid (noc_out_valid),
    .dst_ready (noc_out_ready)
  );

  assign ep_in_flit = noc_in_flit;
  assign ep_in_last = noc_in_last;

  in_state_t     in_state;
  logic [CW-1:0] sel;
  logic [CW-1:0] head_idx;
  logic [CW-1:0] cur_idx;
  logic          routed;
  logic          sel_ready;
  logic          in_xfer;

  // Ingress steering: header index in IN_HEAD, latched sel in IN_ROUTE,
  // otherwise the flit is swallowed (always ready while valid).
  always_comb begin
    head_idx  = noc_in_flit[CH_LSB +: CW];
    cur_idx   = (in_state == IN_ROUTE) ? sel : head_idx;
    routed    = (in_state == IN_ROUTE) ||
                ((in_state == IN_HEAD) && (int'(head_idx) < CHANNELS));
    sel_ready = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      ep_in_valid[i] = routed && noc_in_valid && (cur_idx == CW'(i));
      sel_ready      = sel_ready | ((cur_idx == CW'(i)) && ep_in_ready[i]);
    end
    noc_in_ready = noc_in_valid && (routed ? sel_ready : 1'b1);
    in_xfer      = noc_in_valid && noc_in_ready;
  end

  // Ingress FSM and saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_state   <= IN_HEAD;
      sel        <= '0;
      drop_count <= '0;
    end else begin
      case (in_state)
        IN_HEAD: begin
          if (in_xfer) begin
            if (routed) begin
              if (!noc_in_last) begin
                in_state <= IN_ROUTE;
                sel      <= head_idx;
              end
            end else begin
              if (drop_count != DROP_MAX) begin
                drop_count <= drop_count + DROP_COUNT_WIDTH'(1);
              end
              if (!noc_in_last) begin
                in_state <= IN_DROP;
              end
            end
          end
        end
        IN_ROUTE, IN_DROP: begin
          if (in_xfer && noc_in_last) begin
            in_state <= IN_HEAD;
          end
        end
        default: begin
          in_state <= IN_HEAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpbuffer_channel_mux.sv
// -----------------------------------------------------------------------------
// tb_mpbuffer_channel_mux
// Self-checking bench for mpbuffer_channel_mux with three channels: reset
// checks, directed egress/ingress vector tables, a reset-mid-packet sequence,
// and randomized traffic in both directions against a behavioural model.
// -----------------------------------------------------------------------------
module tb_mpbuffer_channel_mux;
  import mpbuffer_pkg::*;

  localparam int N      = 3;
  localparam int FW     = 32;
  localparam int CH_LSB = 16;
  localparam int CWB    = 2;
  localparam config_t CFG = '{NOC_FLIT_WIDTH: 32'd32};

  logic           clk = 1'b0;
  logic           rst;
  logic [N*FW-1:0] ep_out_flit;
  logic [N-1:0]   ep_out_last, ep_out_valid, ep_out_ready;
  logic [FW-1:0]  noc_out_flit;
  logic           noc_out_last, noc_out_valid, noc_out_ready;
  logic [FW-1:0]  noc_in_flit;
  logic           noc_in_last, noc_in_valid, noc_in_ready;
  logic [FW-1:0]  ep_in_flit;
  logic           ep_in_last;
  logic [N-1:0]   ep_in_valid, ep_in_ready;
  logic [15:0]    drop_count;

  mpbuffer_channel_mux #(
    .CONFIG   (CFG),
    .CHANNELS (N),
    .CH_LSB   (CH_LSB)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ep_out_flit   (ep_out_flit),
    .ep_out_last   (ep_out_last),
    .ep_out_valid  (ep_out_valid),
    .ep_out_ready  (ep_out_ready),
    .noc_out_flit  (noc_out_flit),
    .noc_out_last  (noc_out_last),
    .noc_out_valid (noc_out_valid),
    .noc_out_ready (noc_out_ready),
    .noc_in_flit   (noc_in_flit),
    .noc_in_last   (noc_in_last),
    .noc_in_valid  (noc_in_valid),
    .noc_in_ready  (noc_in_ready),
    .ep_in_flit    (ep_in_flit),
    .ep_in_last    (ep_in_last),
    .ep_in_valid   (ep_in_valid),
    .ep_in_ready   (ep_in_ready),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  bit m_locked = 1'b0;
  int m_owner  = 0;
  int m_ptr    = 0;
  int m_in_mode = 0;   // 0 = expecting header, 1 = routing to m_sel, 2 = dropping
  int m_sel    = 0;
  int m_drops  = 0;

  // Model outputs for the current cycle.
  int            e_src;
  int            e_dest;
  logic          e_nov, e_nol, e_nir;
  logic [FW-1:0] e_nof;
  logic [N-1:0]  e_eor, e_eiv;

  typedef struct {
    logic [2:0] v;
    logic [2:0] l;
    logic       rdy;
    logic       exp_v;
    int         exp_src;
    logic [2:0] exp_rdy;
  } eg_vec_t;

  typedef struct {
    logic       v;
    logic       l;
    logic [1:0] idx;
    logic [2:0] eir;
    logic [2:0] exp_eiv;
    logic       exp_nir;
    int         exp_drop;
  } in_vec_t;

  eg_vec_t eg_tab[16];
  in_vec_t in_tab[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  function automatic logic [FW-1:0] eg_data(input int i, input int r);
    return {16'(i + 1), 16'(r)};
  endfunction

  task automatic model_eval();
    int idx;
    e_src = -1;
    if (m_locked) begin
      e_src = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (e_src < 0 && ep_out_valid[(m_ptr + k) % N]) e_src = (m_ptr + k) % N;
      end
    end
    e_nov = 1'b0;
    e_nol = 1'b0;
    e_nof = '0;
    e_eor = '0;
    if (e_src >= 0) begin
      e_nov = ep_out_valid[e_src];
      e_nof = ep_out_flit[e_src*FW +: FW];
      e_nol = ep_out_last[e_src];
      e_eor[e_src] = ep_out_valid[e_src] & noc_out_ready;
    end
    idx = int'(noc_in_flit[CH_LSB +: CWB]);
    case (m_in_mode)
      0:       e_dest = (idx < N) ? idx : -1;
      1:       e_dest = m_sel;
      default: e_dest = -1;
    endcase
    e_eiv = '0;
    if (e_dest >= 0) begin
      e_eiv[e_dest] = noc_in_valid;
      e_nir = noc_in_valid & ep_in_ready[e_dest];
    end else begin
      e_nir = noc_in_valid;
    end
  endtask

  task automatic model_compare();
    check("model.noc_out_valid", 64'(noc_out_valid), 64'(e_nov));
    if (e_nov) begin
      check("model.noc_out_flit", 64'(noc_out_flit), 64'(e_nof));
      check("model.noc_out_last", 64'(noc_out_last), 64'(e_nol));
    end
    check("model.ep_out_ready", 64'(ep_out_ready), 64'(e_eor));
    check("model.ep_in_valid", 64'(ep_in_valid), 64'(e_eiv));
    check("model.noc_in_ready", 64'(noc_in_ready), 64'(e_nir));
    check("model.ep_in_flit", 64'(ep_in_flit), 64'(noc_in_flit));
    check("model.ep_in_last", 64'(ep_in_last), 64'(noc_in_last));
    check("model.drop_count", 64'(drop_count), 64'(m_drops));
  endtask

  task automatic model_commit();
    if (rst) begin
      m_locked = 1'b0; m_owner = 0; m_ptr = 0;
      m_in_mode = 0; m_sel = 0; m_drops = 0;
    end else begin
      if (e_nov && noc_out_ready) begin
        if (e_nol) begin
          m_locked = 1'b0;
          m_ptr = (e_src + 1) % N;
        end else begin
          m_locked = 1'b1;
          m_owner = e_src;
        end
      end
      if (noc_in_valid && e_nir) begin
        if (m_in_mode == 0) begin
          if (e_dest >= 0) begin
            if (!noc_in_last) begin
              m_in_mode = 1;
              m_sel = e_dest;
            end
          end else begin
            if (m_drops < 65535) m_drops++;
            if (!noc_in_last) m_in_mode = 2;
          end
        end else if (noc_in_last) begin
          m_in_mode = 0;
        end
      end
    end
  endtask

  task automatic settle();
    #4;
    model_eval();
    model_compare();
  endtask

  task automatic advance();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle_inputs();
    ep_out_flit = '0; ep_out_last = '0; ep_out_valid = '0; noc_out_ready = 1'b0;
    noc_in_flit = '0; noc_in_last = 1'b0; noc_in_valid = 1'b0; ep_in_ready = '0;
  endtask

  initial begin
    logic [FW-1:0] tmp;

    // Egress: 3-flit ep0 packet with ep1 waiting, wrap of the 3-way round robin,
    // then backpressure and a mid-packet valid gap on a locked ep1 packet.
    eg_tab[0]  = '{3'b001, 3'b000, 1'b1, 1'b1,  0, 3'b001};
    eg_tab[1]  = '{3'b011, 3'b000, 1'b1, 1'b1,  0, 3'b001};
    eg_tab[2]  = '{3'b011, 3'b001, 1'b1, 1'b1,  0, 3'b001};
    eg_tab[3]  = '{3'b010, 3'b010, 1'b1, 1'b1,  1, 3'b010};
    eg_tab[4]  = '{3'b111, 3'b111, 1'b1, 1'b1,  2, 3'b100};
    eg_tab[5]  = '{3'b111, 3'b111, 1'b1, 1'b1,  0, 3'b001};
    eg_tab[6]  = '{3'b111, 3'b111, 1'b1, 1'b1,  1, 3'b010};
    eg_tab[7]  = '{3'b111, 3'b111, 1'b1, 1'b1,  2, 3'b100};
    eg_tab[8]  = '{3'b111, 3'b111, 1'b1, 1'b1,  0, 3'b001};
    eg_tab[9]  = '{3'b110, 3'b000, 1'b1, 1'b1,  1, 3'b010};
    eg_tab[10] = '{3'b110, 3'b000, 1'b0, 1'b1,  1, 3'b000};
    eg_tab[11] = '{3'b100, 3'b000, 1'b1, 1'b0, -1, 3'b000};
    eg_tab[12] = '{3'b100, 3'b000, 1'b0, 1'b0, -1, 3'b000};
    eg_tab[13] = '{3'b110, 3'b010, 1'b1, 1'b1,  1, 3'b010};
    eg_tab[14] = '{3'b100, 3'b100, 1'b0, 1'b1,  2, 3'b000};
    eg_tab[15] = '{3'b000, 3'b000, 1'b1, 1'b0, -1, 3'b000};

    // Ingress: 4-flit packet to ep1 with a 3-cycle stall, a dropped 2-flit
    // packet (idx 3), then single-flit packets to ep0 and ep2.
    in_tab[0]  = '{1'b1, 1'b0, 2'd1, 3'b111, 3'b010, 1'b1, 0};
    in_tab[1]  = '{1'b1, 1'b0, 2'd3, 3'b101, 3'b010, 1'b0, 0};
    in_tab[2]  = '{1'b1, 1'b0, 2'd3, 3'b101, 3'b010, 1'b0, 0};
    in_tab[3]  = '{1'b1, 1'b0, 2'd3, 3'b101, 3'b010, 1'b0, 0};
    in_tab[4]  = '{1'b1, 1'b0, 2'd3, 3'b111, 3'b010, 1'b1, 0};
    in_tab[5]  = '{1'b1, 1'b0, 2'd0, 3'b111, 3'b010, 1'b1, 0};
    in_tab[6]  = '{1'b1, 1'b1, 2'd0, 3'b111, 3'b010, 1'b1, 0};
    in_tab[7]  = '{1'b1, 1'b0, 2'd3, 3'b000, 3'b000, 1'b1, 0};
    in_tab[8]  = '{1'b1, 1'b1, 2'd0, 3'b000, 3'b000, 1'b1, 1};
    in_tab[9]  = '{1'b1, 1'b1, 2'd0, 3'b001, 3'b001, 1'b1, 1};
    in_tab[10] = '{1'b0, 1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 1};
    in_tab[11] = '{1'b1, 1'b1, 2'd2, 3'b000, 3'b100, 1'b0, 1};
    in_tab[12] = '{1'b1, 1'b1, 2'd2, 3'b100, 3'b100, 1'b1, 1};

    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    model_commit();
    #1;
    rst = 1'b0;

    // Reset state: idle for 10 cycles, readies offered but nothing valid.
    for (int c = 0; c < 10; c++) begin
      idle_inputs();
      noc_out_ready = 1'b1;
      ep_in_ready = 3'b111;
      settle();
      check("reset.noc_out_valid", 64'(noc_out_valid), 64'd0);
      check("reset.ep_out_ready", 64'(ep_out_ready), 64'd0);
      check("reset.ep_in_valid", 64'(ep_in_valid), 64'd0);
      check("reset.noc_in_ready", 64'(noc_in_ready), 64'd0);
      check("reset.drop_count", 64'(drop_count), 64'd0);
      advance();
    end

    for (int r = 0; r < 16; r++) begin
      idle_inputs();
      ep_out_valid = eg_tab[r].v;
      ep_out_last = eg_tab[r].l;
      noc_out_ready = eg_tab[r].rdy;
      for (int i = 0; i < N; i++) ep_out_flit[i*FW +: FW] = eg_data(i, r);
      settle();
      check("tab.eg.noc_out_valid", 64'(noc_out_valid), 64'(eg_tab[r].exp_v));
      check("tab.eg.ep_out_ready", 64'(ep_out_ready), 64'(eg_tab[r].exp_rdy));
      if (eg_tab[r].exp_v) begin
        check("tab.eg.noc_out_flit", 64'(noc_out_flit), 64'(eg_data(eg_tab[r].exp_src, r)));
        check("tab.eg.noc_out_last", 64'(noc_out_last), 64'(eg_tab[r].l[eg_tab[r].exp_src]));
      end
      advance();
    end

    for (int r = 0; r < 13; r++) begin
      idle_inputs();
      tmp = FW'($urandom());
      tmp[CH_LSB +: CWB] = in_tab[r].idx;
      noc_in_flit = tmp;
      noc_in_valid = in_tab[r].v;
      noc_in_last = in_tab[r].l;
      ep_in_ready = in_tab[r].eir;
      settle();
      check("tab.in.ep_in_valid", 64'(ep_in_valid), 64'(in_tab[r].exp_eiv));
      check("tab.in.noc_in_ready", 64'(noc_in_ready), 64'(in_tab[r].exp_nir));
      check("tab.in.drop_count", 64'(drop_count), 64'(in_tab[r].exp_drop));
      advance();
    end

    // Reset mid-packet: lock egress on ep1 and route ingress to ep1, then reset.
    idle_inputs();
    ep_out_valid = 3'b010;
    noc_out_ready = 1'b1;
    for (int i = 0; i < N; i++) ep_out_flit[i*FW +: FW] = eg_data(i, 100);
    noc_in_flit = 32'h0001_0000;
    noc_in_valid = 1'b1;
    ep_in_ready = 3'b111;
    settle();
    advance();
    idle_inputs();
    rst = 1'b1;
    settle();
    advance();
    rst = 1'b0;
    ep_out_valid = 3'b001;
    ep_out_last = 3'b001;
    noc_out_ready = 1'b1;
    for (int i = 0; i < N; i++) ep_out_flit[i*FW +: FW] = eg_data(i, 101);
    noc_in_flit = 32'h0002_0000;
    noc_in_valid = 1'b1;
    noc_in_last = 1'b1;
    ep_in_ready = 3'b111;
    settle();
    check("rstmid.noc_out_valid", 64'(noc_out_valid), 64'd1);
    check("rstmid.noc_out_flit", 64'(noc_out_flit), 64'(eg_data(0, 101)));
    check("rstmid.ep_out_ready", 64'(ep_out_ready), 64'b001);
    check("rstmid.ep_in_valid", 64'(ep_in_valid), 64'b100);
    check("rstmid.drop_count", 64'(drop_count), 64'd0);
    advance();

    // Randomized traffic in both directions with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      ep_out_valid = 3'($urandom());
      for (int i = 0; i < N; i++) begin
        ep_out_last[i] = ($urandom_range(0, 2) == 0);
        ep_out_flit[i*FW +: FW] = FW'($urandom());
      end
      noc_out_ready = ($urandom_range(0, 3) != 0);
      tmp = FW'($urandom());
      tmp[CH_LSB +: CWB] = 2'($urandom_range(0, 3));
      noc_in_flit = tmp;
      noc_in_valid = ($urandom_range(0, 3) != 0);
      noc_in_last = ($urandom_range(0, 2) == 0);
      ep_in_ready = 3'($urandom());
      settle();
      advance();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mpbuffer_channel_mux.md
Name: mpbuffer_channel_mux

Overview:
- Shares one NoC endpoint link between N message-passing buffer endpoints (each an mpbuffer-style packet buffer pair).
- Egress: packet-atomic round-robin arbitration of N endpoint output streams onto one noc_out link.
- Ingress: demultiplexes incoming packets to one endpoint by a channel index carried in the header flit. Packets with an out-of-range index are dropped and counted.
- Sits between the tile's NoC adapter and the N endpoints. Zero added latency; no flit storage.

Parameters:
- CONFIG, 'x, optimsoc config_t; supplies NOC_FLIT_WIDTH (FW below).
- CHANNELS, 2, number of endpoints N (1..8).
- CH_LSB, 16, LSB of the channel index field in the header flit. Field width CW = clog2_width(CHANNELS), a localparam.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- ep_out_flit  in  N*FW  egress flits from endpoints; endpoint i occupies [i*FW +: FW]
- ep_out_last  in  N  last-flit flags
- ep_out_valid  in  N  egress valid
- ep_out_ready  out  N  egress ready (one-hot or zero)
- noc_out_flit  out  FW  flit to NoC
- noc_out_last  out  1  last flag to NoC
- noc_out_valid  out  1  valid to NoC
- noc_out_ready  in  1  ready from NoC
- noc_in_flit  in  FW  flit from NoC
- noc_in_last  in  1  last flag from NoC
- noc_in_valid  in  1  valid from NoC
- noc_in_ready  out  1  ready to NoC
- ep_in_flit  out  FW  ingress flit, broadcast to all endpoints
- ep_in_last  out  1  ingress last flag, broadcast
- ep_in_valid  out  N  ingress valid, one-hot or zero
- ep_in_ready  in  N  ingress ready from endpoints
- drop_count  out  16  number of dropped ingress packets; saturates at 16'hffff

Behaviour:
- One clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: egress state EG_IDLE, rr pointer 0, ingress state IN_HEAD, drop_count 0.
- All data outputs are combinational from registered state and inputs. With all valids low, every valid/ready output is 0. No output is X after reset.
- Transfer rule: a flit transfers in any cycle where its valid and ready are both 1.

Egress FSM (states EG_IDLE, EG_LOCK; register grant[CW]):
- EG_IDLE:
  - The candidate is the first i with ep_out_valid[i], searching from the rr pointer upward with wrap.
  - The candidate is forwarded in the same cycle: noc_out_* = ep_out_*[cand], ep_out_ready[cand] = noc_out_ready.
  - On transfer with last=1 (single-flit packet): stay in EG_IDLE, rr = cand+1 mod N.
  - On transfer with last=0: go to EG_LOCK, grant = cand.
  - With no transfer, nothing is committed; the candidate may change in the next cycle.
- EG_LOCK:
  - Only grant is forwarded. Other endpoints see ready=0.
  - If the granted endpoint drops valid mid-packet, noc_out_valid=0 and the lock is held.
  - On transfer with last=1: go to EG_IDLE, rr = grant+1 mod N.
- rr wrap: for N not a power of two, grant+1 == N maps to 0.

Ingress FSM (states IN_HEAD, IN_ROUTE, IN_DROP; register sel[CW]):
- IN_HEAD:
  - idx = noc_in_flit[CH_LSB +: CW].
  - If idx < N: ep_in_valid[idx] = noc_in_valid and noc_in_ready = ep_in_ready[idx]. On transfer with last=0, go to IN_ROUTE and set sel = idx. On transfer with last=1, stay in IN_HEAD.
  - If idx >= N: noc_in_ready = 1 and all ep_in_valid = 0. On header accept, drop_count increments (saturating). With last=0, go to IN_DROP.
- IN_ROUTE: route to sel. Return to IN_HEAD after a transfer with last=1.
- IN_DROP: noc_in_ready = 1, flits discarded. Return to IN_HEAD after last is accepted.
- ep_in_flit = noc_in_flit and ep_in_last = noc_in_last at all times.
- Ingress and egress are fully independent; simultaneous traffic in both directions is allowed.

Reset mid-packet:
- Both FSMs return to their head/idle states immediately.
- Upstream partial packets are the system's responsibility; the block imposes no recovery.

Decomposition:
- Package mpbuffer_pkg holds:
  - state enums eg_state_t and in_state_t;
  - localparam DROP_COUNT_WIDTH = 16;
  - a function rr_select(valid, ptr, n) that returns the candidate index and a found bit.
- Natural sub-module: noc_rr_packet_arbiter. It contains the egress FSM, the rr pointer and the grant register, and is reusable elsewhere. The ingress demux stays inline.

Test Plan:
- Reset, then all valids 0 for 10 cycles -> all readies/valids 0, drop_count=0.
- N=2: ep0 sends 3-flit packet, ep1 valid from cycle 1, noc_out_ready=1 -> noc_out carries ep0 flits 0..2 in order, then ep1; ep_out_ready[1]=0 during ep0's packet.
- N=3, all endpoints continuously sending single-flit packets -> grant order 0,1,2,0,1,2; N=3 wrap from 2 to 0 is checked.
- Egress backpressure: noc_out_ready toggled 1010, ep0 mid-packet drops valid for 2 cycles -> lock held, no ep1 flit is interleaved, flit order is preserved.
- Ingress: header idx=1 with a 4-flit packet -> only ep_in_valid[1] is asserted for all 4 flits. ep_in_ready[1]=0 for 3 cycles -> noc_in_ready=0 during those cycles.
- Ingress: N=3, header idx=3 with a 2-flit packet -> both flits accepted, no ep_in_valid asserted, drop_count=1. A following idx=0 packet is delivered to ep0.
